// File: rtl/id_ex_stage.sv
// ID stage decode, load-use hazard detection and the ID/EX pipeline register.
// Registered outputs feed the EX stage directly; stall_out and rs*_addr are combinational.
module id_ex_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_id_instr,
    input  logic [XLEN-1:0]   if_id_pc,
    input  logic              if_id_valid,
    input  logic              flush,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    input  logic [XLEN-1:0]   rf_rd_data1,
    input  logic [XLEN-1:0]   rf_rd_data2,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rd_data1,
    output logic [XLEN-1:0]   ex_rd_data2,
    output logic [XLEN-1:0]   ex_sd_imm,
    output logic [XLEN-1:0]   ex_addi_imm,
    output logic [XLEN-1:0]   ex_br_imm,
    output logic              ex_alusrc,
    output logic              ex_sd,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7_5,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    logic [6:0]      opcode;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] addi_imm;
    logic [XLEN-1:0] sd_imm;
    logic [XLEN-1:0] br_imm;

    logic       d_alusrc, d_sd, d_memread, d_memwrite, d_regwrite, d_memtoreg, d_branch;
    logic [1:0] d_aluop;
    logic       uses_rs1, uses_rs2;
    logic       hazard, bubble;

    assign opcode   = if_id_instr[6:0];
    assign rd_addr  = if_id_instr[11:7];
    assign rs1_addr = if_id_instr[19:15];
    assign rs2_addr = if_id_instr[24:20];

    assign addi_imm = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:20]};
    assign sd_imm   = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
    assign br_imm   = {{(XLEN-13){if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                       if_id_instr[30:25], if_id_instr[11:8], 1'b0};

    // Opcode decode into control bits and register-use flags
    always_comb begin
        d_alusrc   = 1'b0;
        d_sd       = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_regwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_branch   = 1'b0;
        d_aluop    = ALU_ADD;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OP_R: begin
                d_regwrite = 1'b1;
                d_aluop    = ALU_RTYPE;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_I: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_aluop    = ALU_ITYPE;
                uses_rs1   = 1'b1;
            end
            OP_LD: begin
                d_alusrc   = 1'b1;
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
                d_regwrite = 1'b1;
                uses_rs1   = 1'b1;
            end
            OP_SD: begin
                d_alusrc   = 1'b1;
                d_sd       = 1'b1;
                d_memwrite = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_BEQ: begin
                d_branch   = 1'b1;
                d_aluop    = ALU_SUB;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            default: ;
        endcase
    end

    // A load in EX whose result the ID instruction needs costs exactly one bubble
    assign hazard = if_id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                    ((uses_rs1 & (ex_rd == rs1_addr)) | (uses_rs2 & (ex_rd == rs2_addr)));
    assign stall_out = hazard & ~flush;
    assign bubble    = flush | stall_out | ~if_id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rd_data1 <= '0;
            ex_rd_data2 <= '0;
            ex_sd_imm   <= '0;
            ex_addi_imm <= '0;
            ex_br_imm   <= '0;
            ex_alusrc   <= 1'b0;
            ex_sd       <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7_5 <= 1'b0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rd_data1 <= '0;
            ex_rd_data2 <= '0;
            ex_sd_imm   <= '0;
            ex_addi_imm <= '0;
            ex_br_imm   <= '0;
            ex_alusrc   <= 1'b0;
            ex_sd       <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7_5 <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_id_pc;
            ex_rd_data1 <= rf_rd_data1;
            ex_rd_data2 <= rf_rd_data2;
            ex_sd_imm   <= sd_imm;
            ex_addi_imm <= addi_imm;
            ex_br_imm   <= br_imm;
            ex_alusrc   <= d_alusrc;
            ex_sd       <= d_sd;
            ex_memread  <= d_memread;
            ex_memwrite <= d_memwrite;
            ex_regwrite <= d_regwrite;
            ex_memtoreg <= d_memtoreg;
            ex_branch   <= d_branch;
            ex_aluop    <= d_aluop;
            ex_rs1      <= rs1_addr;
            ex_rs2      <= rs2_addr;
            ex_rd       <= rd_addr;
            ex_funct3   <= if_id_instr[14:12];
            ex_funct7_5 <= if_id_instr[30];
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_out && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/reset scenarios plus random
// instruction streams, checked against an instruction-level reference model.
module tb_id_ex_stage;

    logic        clk, rst;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid, flush;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rf_rd_data1, rf_rd_data2;
    logic        stall_out, ex_valid;
    logic [63:0] ex_pc, ex_rd_data1, ex_rd_data2, ex_sd_imm, ex_addi_imm, ex_br_imm;
    logic        ex_alusrc, ex_sd, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch;
    logic [1:0]  ex_aluop;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5;
    logic [15:0] stall_count;

    id_ex_stage #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_data1(ex_rd_data1), .ex_rd_data2(ex_rd_data2),
        .ex_sd_imm(ex_sd_imm), .ex_addi_imm(ex_addi_imm), .ex_br_imm(ex_br_imm),
        .ex_alusrc(ex_alusrc), .ex_sd(ex_sd), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc, d1, d2, sd_imm, addi_imm, br_imm;
        logic        alusrc, sd, memread, memwrite, regwrite, memtoreg, branch;
        logic [1:0]  aluop;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  funct3;
        logic        funct7_5;
    } ex_t;

    int   checks = 0;
    int   failures = 0;
    ex_t  m_ex;
    int   m_cnt;
    logic m_stall;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t observed();
        ex_t o;
        o = '{ex_valid, ex_pc, ex_rd_data1, ex_rd_data2, ex_sd_imm, ex_addi_imm, ex_br_imm,
              ex_alusrc, ex_sd, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch,
              ex_aluop, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5};
        return o;
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    // Instruction-level model of what EX should hold after accepting ins
    function automatic ex_t model_decode(input logic [31:0] ins, input logic [63:0] pc,
                                         input logic [63:0] d1, input logic [63:0] d2);
        ex_t e;
        logic signed [31:0] si;
        longint sv;
        e = '0;
        si = ins;
        e.valid = 1'b1;
        e.pc = pc;
        e.d1 = d1;
        e.d2 = d2;
        sv = si >>> 20;
        e.addi_imm = sv;
        sv = si >>> 25;
        sv = sv * 32 + longint'(int'(ins[11:7]));
        e.sd_imm = sv;
        sv = si >>> 31;
        sv = sv * 4096 + longint'(2048 * int'(ins[7]) + 32 * int'(ins[30:25]) + 2 * int'(ins[11:8]));
        e.br_imm = sv;
        case (ins[6:0])
            7'h33: begin e.regwrite = 1; e.aluop = 2; end
            7'h13: begin e.regwrite = 1; e.alusrc = 1; e.aluop = 3; end
            7'h03: begin e.alusrc = 1; e.memread = 1; e.memtoreg = 1; e.regwrite = 1; end
            7'h23: begin e.alusrc = 1; e.sd = 1; e.memwrite = 1; end
            7'h63: begin e.branch = 1; e.aluop = 1; end
            default: ;
        endcase
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.funct3 = ins[14:12];
        e.funct7_5 = ins[30];
        return e;
    endfunction

    // One cycle: drive ID inputs, check combinational outputs, clock, check EX register
    task automatic step(input logic [31:0] ins, input logic v, input logic f,
                        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] pc);
        logic exp_stall;
        if_id_instr = ins;
        if_id_valid = v;
        flush = f;
        rf_rd_data1 = d1;
        rf_rd_data2 = d2;
        if_id_pc = pc;
        #1;
        exp_stall = v && m_ex.valid && m_ex.memread && (m_ex.rd != 0) && !f &&
                    ((reads_rs1(ins) && m_ex.rd == ins[19:15]) ||
                     (reads_rs2(ins) && m_ex.rd == ins[24:20]));
        check("rs1_addr", rs1_addr, ins[19:15]);
        check("rs2_addr", rs2_addr, ins[24:20]);
        check("stall_out", stall_out, exp_stall);
        @(posedge clk);
        if (f || exp_stall || !v) m_ex = '0;
        else m_ex = model_decode(ins, pc, d1, d2);
        if (exp_stall && m_cnt < 65535) m_cnt++;
        m_stall = exp_stall;
        #1;
        check("ex_regs", observed(), m_ex);
        check("stall_count", stall_count, m_cnt);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0] ops [6];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 5)];
        ins[11:7] = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        logic [31:0] ins;
        logic [63:0] r1, r2, pc;
        rst = 1'b1;
        if_id_instr = 32'h0;
        if_id_pc = 64'h0;
        if_id_valid = 1'b0;
        flush = 1'b0;
        rf_rd_data1 = 64'h0;
        rf_rd_data2 = 64'h0;
        m_ex = '0;
        m_cnt = 0;
        m_stall = 1'b0;
        #12;
        check("reset_ex_regs", observed(), ex_t'(0));
        check("reset_stall_count", stall_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi x5,x0,-3
        step(32'hFFD00293, 1, 0, 64'h11, 64'h22, 64'h1000);
        check("addi_imm", ex_addi_imm, 64'hFFFF_FFFF_FFFF_FFFD);
        check("addi_ctl", {ex_valid, ex_alusrc, ex_sd, ex_rd, ex_aluop, ex_regwrite},
              {1'b1, 1'b1, 1'b0, 5'd5, 2'b11, 1'b1});

        // sd x6,-8(x2)
        step(32'hFE613C23, 1, 0, 64'h99, 64'h1234, 64'h1004);
        check("sd_imm", ex_sd_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("sd_ctl", {ex_sd, ex_alusrc, ex_memwrite, ex_regwrite}, 4'b1110);
        check("sd_data2", ex_rd_data2, 64'h1234);

        // ld x7,0(x1) then dependent add x8,x7,x3: one bubble
        step(32'h0000B383, 1, 0, 64'h5, 64'h6, 64'h1008);
        step(32'h00338433, 1, 0, 64'h7, 64'h8, 64'h100C);
        check("lu_bubble", {ex_valid, ex_memread, ex_regwrite, ex_aluop}, 5'b0);
        step(32'h00338433, 1, 0, 64'h7, 64'h8, 64'h100C);
        check("lu_add", {ex_valid, ex_rs1, ex_rs2, ex_aluop}, {1'b1, 5'd7, 5'd3, 2'b10});
        check("lu_count", stall_count, 16'd1);

        // load to x0 never stalls
        step(32'h0000B003, 1, 0, 64'h5, 64'h6, 64'h1010);
        step(32'h00338433, 1, 0, 64'h7, 64'h8, 64'h1014);
        check("x0_no_stall", {ex_valid, ex_rs1}, {1'b1, 5'd7});

        // flush coinciding with a hazard
        step(32'h0000B383, 1, 0, 64'h5, 64'h6, 64'h1018);
        step(32'h00338433, 1, 1, 64'h7, 64'h8, 64'h101C);
        check("flush_bubble", ex_valid, 1'b0);
        check("flush_count", stall_count, 16'd1);

        // asynchronous reset mid-stream
        step(32'hFFD00293, 1, 0, 64'h1, 64'h2, 64'h1020);
        #3 rst = 1'b1;
        #1;
        check("async_rst_ex_regs", observed(), ex_t'(0));
        check("async_rst_count", stall_count, 16'd0);
        m_ex = '0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;

        // unknown opcode still flows as valid with no control
        step(32'h0000007F, 1, 0, 64'h3, 64'h4, 64'h2000);
        check("unknown_op", {ex_valid, ex_alusrc, ex_sd, ex_memread, ex_memwrite,
                             ex_regwrite, ex_memtoreg, ex_branch, ex_aluop}, 10'b10_0000_0000);

        // random streams; IF/ID holds its instruction while stalled
        ins = rand_instr();
        for (int i = 0; i < 400; i++) begin
            if (!m_stall) begin
                ins = rand_instr();
                r1 = {$urandom, $urandom};
                r2 = {$urandom, $urandom};
                pc = {$urandom, $urandom};
            end
            step(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0), r1, r2, pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute stage of the pipelined RISC-V core: generates control and immediates from the IF/ID instruction, detects load-use hazards, and registers everything into the ID/EX pipeline register. Its registered outputs directly feed the EX-stage ALU operand-2 select mux: `ex_rd_data2`, `ex_sd_imm`, `ex_addi_imm`, `ex_alusrc` and `ex_sd`. It also drives the PC/IF-ID stall and inserts bubbles on stall or flush.

## Interface
- XLEN, 64, datapath width
- CNT_W, 16, width of stall-cycle counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_id_instr  in  32  instruction in ID
- if_id_pc  in  XLEN  PC of that instruction
- if_id_valid  in  1  ID slot holds a real instruction
- flush  in  1  branch taken in later stage; kill ID instruction
- rs1_addr, rs2_addr  out  5 each  combinational register-file read addresses (instr[19:15], instr[24:20])
- rf_rd_data1, rf_rd_data2  in  XLEN  register-file read data (same cycle)
- stall_out  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot valid
- ex_pc, ex_rd_data1, ex_rd_data2, ex_sd_imm, ex_addi_imm, ex_br_imm  out  XLEN each
- ex_alusrc, ex_sd, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch  out  1 each
- ex_aluop  out  2  00 add, 01 sub (branch), 10 R-type funct, 11 I-type funct3
- ex_rs1, ex_rs2, ex_rd  out  5 each
- ex_funct3  out  3; ex_funct7_5  out  1 (instr[30])
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Decode by opcode instr[6:0]:
  - R 0110011: regwrite, aluop=10
  - I 0010011: regwrite, alusrc, aluop=11
  - ld 0000011: alusrc, memread, memtoreg, regwrite, aluop=00
  - sd 0100011: alusrc, sd, memwrite, aluop=00
  - beq 1100011: branch, aluop=01
  - Any other opcode: all control bits 0; valid still propagates.
- Immediates (sign-extended to XLEN):
  - addi_imm = instr[31:20]
  - sd_imm = {instr[31:25], instr[11:7]}
  - br_imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
- rs1 use: R, I, ld, sd, beq. rs2 use: R, sd, beq.
- hazard = if_id_valid & ex_valid & ex_memread & (ex_rd≠0) & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
- stall_out = hazard & ~flush.
- Register update each clock, priority order:
  1. rst: all outputs 0.
  2. flush, stall_out, or ~if_id_valid: bubble. ex_valid=0, every control bit 0, every data/address field 0.
  3. Otherwise load decoded values, ex_valid=1.
- stall_count increments on each cycle stall_out=1; saturates at all-ones.

## Timing
- Reset: asynchronous clear of every registered output to 0, including mid-operation; first load on the first rising edge after rst deasserts.
- Latency: ID→EX is 1 cycle.
- Load-use sequence:
  - Cycle n: ld in EX, dependent instruction in ID → stall_out=1 during n.
  - Edge n+1: bubble enters EX; IF/ID holds (external).
  - Cycle n+1: stall_out=0, because the EX slot now holds a bubble (memread=0).
  - Edge n+2: dependent instruction enters EX.
- Exactly one bubble per load-use hazard.
- Load with rd=x0 never stalls.
- flush with hazard in the same cycle: bubble, stall_out=0, counter not incremented.
- stall_out and rs*_addr are purely combinational from inputs and current ID/EX state; there is no path from stall_out back into the hazard logic.

## Test plan
- Reset then addi x5,x0,-3 (0xFFD00293), valid → next edge: ex_valid=1, ex_addi_imm=0xFFFF_FFFF_FFFF_FFFD, ex_alusrc=1, ex_sd=0, ex_rd=5, ex_aluop=11, ex_regwrite=1.
- sd x6,-8(x2) (0xFE613C23), rf_rd_data2=0x1234 → ex_sd_imm=0xFFFF_FFFF_FFFF_FFF8, ex_sd=1, ex_alusrc=1, ex_memwrite=1, ex_rd_data2=0x1234, ex_regwrite=0.
- ld x7,0(x1) (0x0000B383) followed by add x8,x7,x3 (0x00338433):
  - stall_out=1 for exactly one cycle; one cycle of ex_valid=0 with all controls 0.
  - add then appears in EX with ex_rs1=7, ex_rs2=3, ex_aluop=10.
  - stall_count=1.
- Same load-use pair, but ld uses rd=x0 → no stall; add enters EX on the very next edge.
- Load-use pair with flush=1 in the hazard cycle → stall_out=0, bubble loaded, stall_count unchanged.
- Assert rst asynchronously mid-stream with ex_valid=1 → all ex_* and stall_count read 0 before the next clock edge; unknown opcode 0x0000007F after reset → ex_valid=1, all control bits 0.
